// File: rtl/bus_dma_master.sv
// Single-channel block-copy DMA bus master.
// Each word is moved as a read-address cycle, a read-data cycle and a write
// cycle. The bus request is held for the whole transfer so the arbiter never
// hands the bus away between words of one block.
module bus_dma_master (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  src_addr,
    input  logic [7:0]  dst_addr,
    input  logic [7:0]  length,
    output logic        M_req,
    input  logic        M_grant,
    output logic        M_wr,
    output logic [7:0]  M_address,
    output logic [31:0] M_dout,
    input  logic [31:0] M_din,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR      = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t      state_q,     state_d;
    logic [7:0]  src_ptr_q,   src_ptr_d;
    logic [7:0]  dst_ptr_q,   dst_ptr_d;
    logic [7:0]  remaining_q, remaining_d;
    logic [31:0] data_reg_q,  data_reg_d;

    // State and datapath registers; reset abandons any transfer immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            src_ptr_q   <= 8'd0;
            dst_ptr_q   <= 8'd0;
            remaining_q <= 8'd0;
            data_reg_q  <= 32'd0;
        end else begin
            state_q     <= state_d;
            src_ptr_q   <= src_ptr_d;
            dst_ptr_q   <= dst_ptr_d;
            remaining_q <= remaining_d;
            data_reg_q  <= data_reg_d;
        end
    end

    // Next-state logic: everything holds unless a state explicitly advances it.
    always_comb begin
        state_d     = state_q;
        src_ptr_d   = src_ptr_q;
        dst_ptr_d   = dst_ptr_q;
        remaining_d = remaining_q;
        data_reg_d  = data_reg_q;

        case (state_q)
            IDLE: begin
                // start is only looked at here, so a pulse during a transfer
                // has no effect at all.
                if (start) begin
                    if (length != 8'd0) begin
                        src_ptr_d   = src_addr;
                        dst_ptr_d   = dst_addr;
                        remaining_d = length;
                        state_d     = RD_ADDR;
                    end else begin
                        state_d     = DONE;
                    end
                end
            end

            RD_ADDR: begin
                if (M_grant) begin
                    state_d = RD_DATA;
                end
            end

            RD_DATA: begin
                // The slave returns data the cycle after the accepted address,
                // independent of the grant level in this cycle.
                data_reg_d = M_din;
                state_d    = WR;
            end

            WR: begin
                if (M_grant) begin
                    // 8-bit pointers wrap naturally from 0xFF to 0x00.
                    src_ptr_d   = src_ptr_q + 8'd1;
                    dst_ptr_d   = dst_ptr_q + 8'd1;
                    remaining_d = remaining_q - 8'd1;
                    if (remaining_q == 8'd1) begin
                        state_d = DONE;
                    end else begin
                        state_d = RD_ADDR;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Bus and status outputs decoded from the current state; M_wr also gates
    // on the live grant so a stalled write never reaches the slave.
    always_comb begin
        M_req     = 1'b0;
        M_wr      = 1'b0;
        M_address = 8'd0;
        busy      = 1'b1;
        done      = 1'b0;

        case (state_q)
            IDLE: begin
                busy = 1'b0;
            end
            RD_ADDR: begin
                M_req     = 1'b1;
                M_address = src_ptr_q;
            end
            RD_DATA: begin
                M_req     = 1'b1;
                M_address = src_ptr_q;
            end
            WR: begin
                M_req     = 1'b1;
                M_wr      = M_grant;
                M_address = dst_ptr_q;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign M_dout = data_reg_q;

endmodule

// File: tb/tb_bus_dma_master.sv
// Self-checking bench for bus_dma_master: a word-addressed slave memory, a
// registered one-cycle arbiter, and a scoreboard of expected read addresses
// and write transactions filled when each copy is started.
module tb_bus_dma_master;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  src_addr;
    logic [7:0]  dst_addr;
    logic [7:0]  length;
    logic        M_req;
    logic        M_grant;
    logic        M_wr;
    logic [7:0]  M_address;
    logic [31:0] M_dout;
    logic [31:0] M_din;
    logic        busy;
    logic        done;

    logic [31:0] mem [256];
    logic        grant_q;
    logic        grant_en;
    logic [31:0] din_q;

    logic [7:0]  rd_q [$];
    logic [39:0] wr_q [$];

    int n_pass;
    int n_total;
    int done_cnt;
    logic req_seen;
    logic prev_rd;

    bus_dma_master dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .length    (length),
        .M_req     (M_req),
        .M_grant   (M_grant),
        .M_wr      (M_wr),
        .M_address (M_address),
        .M_dout    (M_dout),
        .M_din     (M_din),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Arbiter grants one cycle after the request; grant_en lets tests stall it.
    always @(posedge clk or posedge reset) begin
        if (reset) grant_q <= 1'b0;
        else       grant_q <= M_req;
    end
    assign M_grant = grant_q & grant_en;

    // Slave returns the addressed word one cycle later.
    always @(posedge clk) din_q <= mem[M_address];
    assign M_din = din_q;

    // Scoreboard monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (!reset) begin
            if (M_req) req_seen <= 1'b1;
            if (done)  done_cnt <= done_cnt + 1;
            if (M_req && !M_wr && M_grant && !prev_rd) begin
                n_total++;
                if (rd_q.size() == 0) begin
                    $display("FAIL rd_unexpected addr=%02h", M_address);
                end else begin
                    logic [7:0] ea;
                    ea = rd_q.pop_front();
                    if (M_address !== ea)
                        $display("FAIL rd_addr got=%02h exp=%02h", M_address, ea);
                    else
                        n_pass++;
                end
            end
            prev_rd <= M_req && !M_wr && M_grant;
            if (M_req && M_wr && M_grant) begin
                n_total++;
                if (wr_q.size() == 0) begin
                    $display("FAIL wr_unexpected addr=%02h data=%08h", M_address, M_dout);
                end else begin
                    logic [39:0] ew;
                    ew = wr_q.pop_front();
                    if ({M_address, M_dout} !== ew)
                        $display("FAIL wr_txn got=%02h/%08h exp=%02h/%08h",
                                 M_address, M_dout, ew[39:32], ew[31:0]);
                    else
                        n_pass++;
                end
            end
        end else begin
            prev_rd <= 1'b0;
        end
    end

    task automatic do_start(input logic [7:0] s, input logic [7:0] d,
                            input logic [7:0] len, input bit expect_run);
        @(negedge clk);
        start    = 1'b1;
        src_addr = s;
        dst_addr = d;
        length   = len;
        if (expect_run) begin
            for (int i = 0; i < len; i++) begin
                logic [7:0] sa;
                logic [7:0] da;
                sa = s + i[7:0];
                da = d + i[7:0];
                rd_q.push_back(sa);
                wr_q.push_back({da, mem[sa]});
            end
        end
        @(negedge clk);
        start    = 1'b0;
        src_addr = 8'h00;
        dst_addr = 8'h00;
        length   = 8'h00;
    endtask

    // Counts negedges since the start edge until done is seen.
    task automatic wait_done(input int max, output int n);
        n = 1;
        while (done !== 1'b1 && n < max) begin
            @(negedge clk);
            n++;
        end
        n_total++;
        if (done !== 1'b1) $display("FAIL done_timeout waited=%0d", n);
        else n_pass++;
    endtask

    task automatic check_finished(input string name, input int done_before);
        @(negedge clk);
        #1;
        n_total++;
        if (done_cnt !== done_before + 1)
            $display("FAIL %s_done_count got=%0d exp=%0d", name, done_cnt, done_before + 1);
        else n_pass++;
        n_total++;
        if (wr_q.size() != 0 || rd_q.size() != 0)
            $display("FAIL %s_queue_left wr=%0d rd=%0d exp=0", name, wr_q.size(), rd_q.size());
        else n_pass++;
        n_total++;
        if (busy !== 1'b0 || done !== 1'b0 || M_req !== 1'b0 || M_address !== 8'h00)
            $display("FAIL %s_idle busy=%b done=%b req=%b addr=%02h exp=0", name,
                     busy, done, M_req, M_address);
        else n_pass++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        n_total++;
        if ({M_req, M_wr, busy, done} !== 4'b0 || M_address !== 8'h00 || M_dout !== 32'h0)
            $display("FAIL reset_outputs req=%b wr=%b busy=%b done=%b addr=%02h dout=%08h exp=0",
                     M_req, M_wr, busy, done, M_address, M_dout);
        else n_pass++;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_copy();
        int n;
        int db;
        mem[8'h10] = 32'hAAAA_0001;
        mem[8'h11] = 32'hBBBB_0002;
        mem[8'h12] = 32'hCCCC_0003;
        db = done_cnt;
        do_start(8'h10, 8'h40, 8'd3, 1'b1);
        n_total++;
        if (busy !== 1'b1 || M_req !== 1'b1)
            $display("FAIL copy_busy busy=%b req=%b exp=1", busy, M_req);
        else n_pass++;
        wait_done(60, n);
        // one arbiter latency cycle, 3 cycles per word, then DONE
        n_total++;
        if (n != 11) $display("FAIL copy_latency got=%0d exp=11", n);
        else n_pass++;
        check_finished("copy", db);
    endtask

    task automatic test_zero_length();
        int n;
        int db;
        db = done_cnt;
        req_seen = 1'b0;
        do_start(8'h22, 8'h33, 8'd0, 1'b0);
        wait_done(10, n);
        n_total++;
        if (n != 1) $display("FAIL zero_latency got=%0d exp=1", n);
        else n_pass++;
        check_finished("zero", db);
        n_total++;
        if (req_seen !== 1'b0) $display("FAIL zero_req got=%b exp=0", req_seen);
        else n_pass++;
    endtask

    task automatic test_grant_loss();
        int n;
        int db;
        int guard;
        mem[8'h20] = 32'h1111_2222;
        mem[8'h21] = 32'h3333_4444;
        mem[8'h22] = 32'h5555_6666;
        db = done_cnt;
        do_start(8'h20, 8'h50, 8'd3, 1'b1);
        guard = 0;
        while (!(M_wr && M_grant) && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        @(posedge clk);
        #1 grant_en = 1'b0;
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_total++;
            if (M_wr !== 1'b0 || M_req !== 1'b1 || M_address !== 8'h51 || M_dout !== 32'h3333_4444)
                $display("FAIL stall_hold wr=%b req=%b addr=%02h dout=%08h exp=0/1/51/33334444",
                         M_wr, M_req, M_address, M_dout);
            else n_pass++;
            if (i < 3) @(posedge clk);
        end
        @(posedge clk);
        #1 grant_en = 1'b1;
        wait_done(60, n);
        check_finished("grant_loss", db);
    endtask

    task automatic test_wrap();
        int n;
        int db;
        mem[8'hFE] = 32'hFEFE_0000;
        mem[8'hFF] = 32'hFFFF_0001;
        mem[8'h00] = 32'h0000_0002;
        db = done_cnt;
        do_start(8'hFE, 8'h80, 8'd3, 1'b1);
        wait_done(60, n);
        n_total++;
        if (n != 11) $display("FAIL wrap_latency got=%0d exp=11", n);
        else n_pass++;
        check_finished("wrap", db);
    endtask

    task automatic test_reset_mid();
        int db;
        int guard;
        db = done_cnt;
        do_start(8'h30, 8'h60, 8'd5, 1'b1);
        guard = 0;
        while (!(M_wr && M_grant) && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        n_total++;
        if ({M_req, M_wr, busy, done} !== 4'b0 || M_address !== 8'h00 || M_dout !== 32'h0)
            $display("FAIL midreset_outputs req=%b wr=%b busy=%b done=%b addr=%02h dout=%08h exp=0",
                     M_req, M_wr, busy, done, M_address, M_dout);
        else n_pass++;
        n_total++;
        if (wr_q.size() != 4 || rd_q.size() != 3)
            $display("FAIL midreset_progress wr_left=%0d rd_left=%0d exp=4/3", wr_q.size(), rd_q.size());
        else n_pass++;
        wr_q.delete();
        rd_q.delete();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        n_total++;
        if (done_cnt !== db || busy !== 1'b0)
            $display("FAIL midreset_nodone done_cnt=%0d busy=%b exp=%0d/0", done_cnt, busy, db);
        else n_pass++;
        begin
            int n;
            mem[8'h38] = 32'hDEAD_BEEF;
            mem[8'h39] = 32'hCAFE_F00D;
            do_start(8'h38, 8'h68, 8'd2, 1'b1);
            wait_done(60, n);
            n_total++;
            if (n != 8) $display("FAIL post_reset_latency got=%0d exp=8", n);
            else n_pass++;
            check_finished("post_reset", db);
        end
    endtask

    task automatic test_busy_start();
        int n;
        int db;
        for (int i = 0; i < 4; i++) mem[8'h08 + i] = $urandom;
        db = done_cnt;
        do_start(8'h08, 8'h70, 8'd4, 1'b1);
        repeat (3) @(negedge clk);
        start    = 1'b1;
        src_addr = 8'h90;
        dst_addr = 8'hA0;
        length   = 8'd7;
        @(negedge clk);
        start  = 1'b0;
        length = 8'd0;
        wait_done(80, n);
        check_finished("busy_start", db);
        repeat (4) @(negedge clk);
        n_total++;
        if (done_cnt !== db + 1 || busy !== 1'b0)
            $display("FAIL busy_start_extra done_cnt=%0d busy=%b exp=%0d/0", done_cnt, busy, db + 1);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int n;
        int db;
        for (int i = 0; i < 6; i++) mem[8'hC0 + i] = $urandom;
        db = done_cnt;
        do_start(8'hC0, 8'hD0, 8'd3, 1'b1);
        wait_done(60, n);
        check_finished("b2b_first", db);
        do_start(8'hC3, 8'hD3, 8'd3, 1'b1);
        wait_done(60, n);
        n_total++;
        if (n != 11) $display("FAIL b2b_latency got=%0d exp=11", n);
        else n_pass++;
        check_finished("b2b_second", db + 1);
    endtask

    initial begin
        n_pass   = 0;
        n_total  = 0;
        done_cnt = 0;
        req_seen = 1'b0;
        prev_rd  = 1'b0;
        grant_en = 1'b1;
        start    = 1'b0;
        src_addr = 8'h00;
        dst_addr = 8'h00;
        length   = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 32'h5A00_0000 | i;

        test_reset();
        test_copy();
        test_zero_length();
        test_grant_loss();
        test_wrap();
        test_reset_mid();
        test_busy_start();
        test_back_to_back();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/bus_dma_master.md
BUS_DMA_MASTER -- requirements
Module: bus_dma_master

Interface
REQ-001 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset  in  1  reset; asynchronous, active-high.
REQ-003 SHALL have port start  in  1  one-cycle pulse requesting a block copy; sampled only in IDLE.
REQ-004 SHALL have ports src_addr, dst_addr  in  8 each  first source / destination word address; sampled with start.
REQ-005 SHALL have port length  in  8  words to copy, 0..255; sampled with start.
REQ-006 SHALL have port M_req  out  1  bus request to arbiter.
REQ-007 SHALL have port M_grant  in  1  bus grant from arbiter (registered in arbiter, so it arrives at least 1 cycle after M_req).
REQ-008 SHALL have port M_wr  out  1  1 = write, 0 = read.
REQ-009 SHALL have port M_address  out  8  slave address.
REQ-010 SHALL have port M_dout  out  32  write data to bus.
REQ-011 SHALL have port M_din  in  32  read data from bus, valid the cycle after a granted read address.
REQ-012 SHALL have ports busy  out  1  and done  out  1  (transfer active; one-cycle completion pulse).

Function
REQ-013 SHALL implement states IDLE, RD_ADDR, RD_DATA, WR, DONE.
REQ-014 IDLE: on start=1 with length!=0, SHALL latch src_ptr=src_addr, dst_ptr=dst_addr, remaining=length, then go to RD_ADDR; with length=0, SHALL go straight to DONE with no bus request.
REQ-015 RD_ADDR: SHALL drive M_req=1, M_wr=0, M_address=src_ptr; if M_grant=1 go to RD_DATA, else stay (stall, no side effects).
REQ-016 RD_DATA: SHALL hold M_req=1, M_wr=0; SHALL capture M_din into data_reg at the end of the cycle regardless of M_grant; then go to WR.
REQ-017 WR: SHALL drive M_req=1, M_address=dst_ptr, M_dout=data_reg; M_wr=1 only while M_grant=1.
REQ-018 WR with M_grant=1: SHALL increment src_ptr and dst_ptr by 1 (mod 256, 0xFF wraps to 0x00) and decrement remaining; if remaining was 1 go to DONE, else RD_ADDR.
REQ-019 WR with M_grant=0: SHALL stay in WR; pointers, remaining and data_reg unchanged.
REQ-020 DONE: SHALL assert done=1 for exactly one cycle, M_req=0, then go to IDLE.
REQ-021 busy SHALL be 1 in RD_ADDR, RD_DATA, WR, DONE; 0 in IDLE.
REQ-022 M_req SHALL be 1 in RD_ADDR, RD_DATA, WR only; held continuously for the whole transfer (no release between words).
REQ-023 start while busy=1 SHALL be ignored; the transfer in progress is not affected.
REQ-024 With grant held continuously, each word SHALL take exactly 3 cycles (RD_ADDR, RD_DATA, WR); total = 3*length + 1 (DONE) cycles after start, plus arbiter grant latency.
REQ-025 M_address SHALL be 0 in IDLE and DONE; M_dout SHALL equal data_reg at all times; M_wr SHALL be 0 outside WR.

Reset
REQ-026 On reset=1 SHALL immediately (asynchronously) enter IDLE and clear src_ptr, dst_ptr, remaining, data_reg to 0; M_req=0, M_wr=0, M_address=0, M_dout=0, busy=0, done=0.
REQ-027 Reset mid-transfer SHALL abandon the transfer without a done pulse; words already written stay written; M_wr SHALL drop to 0 in the same cycle reset asserts.

Verification
REQ-028 Copy: slaves preloaded 0x10..0x12 = A,B,C; start src=0x10 dst=0x40 length=3, grant held -> writes A,B,C to 0x40..0x42, one done pulse 10 cycles after grant first seen.
REQ-029 Zero length: start length=0 -> done pulse the next cycle, M_req never asserted.
REQ-030 Grant loss: drop M_grant for 4 cycles during WR of word 2 -> M_wr=0 while stalled, address/data held, copied data still correct.
REQ-031 Wrap: src=0xFE dst=0x80 length=3 -> reads 0xFE, 0xFF, 0x00 in order; writes to 0x80..0x82.
REQ-032 Reset mid-transfer: assert reset in RD_DATA of word 2 of a length-5 copy -> all outputs 0 same cycle, no done, next start works normally.
REQ-033 Busy start: pulse start with new params during a length-4 copy -> ignored; original 4 words copied, one done pulse.
